multdiv_unit: RTL and testbench

MULTDIV_UNIT -- requirements
Module: multdiv_unit

---
 rtl/multdiv_pkg.sv | 15 +
 rtl/multdiv_counter.sv | 25 ++
 rtl/multdiv_unit.sv | 152 +++++++++++++++
 tb/tb_multdiv_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative signed multiply/divide unit.
package multdiv_pkg;

   localparam int WIDTH = 32;
   localparam int ITERS = 32;
   localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE,
      MULT,
      DIV,
      DONE
   } state_t;

endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter: cleared on start or reset, counts while enabled,
// flags the last iteration of an operation.
module multdiv_counter #(
   parameter int ITERS = 32
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);

   logic [5:0] count;

   always_ff @(posedge clock) begin
      if (!reset || clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + 6'd1;
      end
   end

   assign tc = (count == 6'(ITERS - 1));

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply (shift-add) and divide (restoring) unit,
// one step per cycle on operand magnitudes with the sign applied at the end.
module multdiv_unit #(
   parameter int WIDTH = 32,
   parameter int ITERS = 32
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic signed [WIDTH-1:0] data_operandA,
   input  logic signed [WIDTH-1:0] data_operandB,
   input  logic                    ctrl_MULT,
   input  logic                    ctrl_DIV,
   output logic signed [WIDTH-1:0] data_result,
   output logic                    data_exception,
   output logic                    data_resultRDY,
   output logic                    busy
);

   import multdiv_pkg::*;

   state_t           state;
   state_t           state_nxt;
   logic             start;
   logic             tc;
   logic [WIDTH-1:0] mcand_r;
   logic [WIDTH-1:0] acc_r;
   logic [WIDTH-1:0] mplier_r;
   logic             neg_r;
   logic             dz_r;
   logic             ovf_r;
   logic [WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0] mplier_nxt;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_diff;
   logic             div_ge;
   logic             unused_diff_msb;
   logic [WIDTH:0]   mult_fin;
   logic [WIDTH:0]   div_fin;

   function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] x);
      return x[WIDTH-1] ? -x : x;
   endfunction

   // Returns {exception, result}; exception when the signed product does not fit.
   function automatic logic [WIDTH:0] finish_mult(input logic [2*WIDTH-1:0] m,
                                                  input logic neg);
      logic signed [2*WIDTH-1:0] p;
      logic                      ovf;
      p   = neg ? -m : m;
      ovf = !((&p[2*WIDTH-1:WIDTH-1]) || !(|p[2*WIDTH-1:WIDTH-1]));
      return {ovf, p[WIDTH-1:0]};
   endfunction

   function automatic logic [WIDTH:0] finish_div(input logic [WIDTH-1:0] q,
                                                 input logic neg,
                                                 input logic dz,
                                                 input logic ovf);
      if (dz) begin
         return {1'b1, {WIDTH{1'b0}}};
      end else if (ovf) begin
         return {1'b1, INT_MIN};
      end
      return {1'b0, (neg ? -q : q)};
   endfunction

   assign start          = ctrl_MULT | ctrl_DIV;
   assign busy           = (state == MULT) || (state == DIV);
   assign data_resultRDY = (state == DONE);

   multdiv_counter #(.ITERS(ITERS)) u_counter (
      .clock (clock),
      .reset (reset),
      .clr   (start),
      .en    (busy),
      .tc    (tc)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         MULT, DIV:  if (tc) state_nxt = DONE;
         default:    state_nxt = IDLE;
      endcase
      if (start) begin
         state_nxt = ctrl_MULT ? MULT : DIV;
      end
   end

   // Iteration step: one multiplier bit or one quotient bit per cycle
   assign mul_sum   = {1'b0, acc_r} + (mplier_r[0] ? {1'b0, mcand_r} : '0);
   assign div_shift = {acc_r, mplier_r[WIDTH-1]};
   assign div_ge    = (div_shift >= {1'b0, mcand_r});
   assign div_diff  = div_shift - {1'b0, mcand_r};
   assign unused_diff_msb = div_diff[WIDTH];

   always_comb begin
      acc_nxt    = acc_r;
      mplier_nxt = mplier_r;
      if (state == MULT) begin
         acc_nxt    = mul_sum[WIDTH:1];
         mplier_nxt = {mul_sum[0], mplier_r[WIDTH-1:1]};
      end else if (div_ge) begin
         acc_nxt    = div_diff[WIDTH-1:0];
         mplier_nxt = {mplier_r[WIDTH-2:0], 1'b1};
      end else begin
         acc_nxt    = div_shift[WIDTH-1:0];
         mplier_nxt = {mplier_r[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clock) begin
      if (start) begin
         neg_r  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
         dz_r   <= (data_operandB == '0);
         ovf_r  <= (data_operandA == INT_MIN) && (data_operandB == '1);
         acc_r  <= '0;
         if (ctrl_MULT) begin
            mcand_r  <= mag(data_operandA);
            mplier_r <= mag(data_operandB);
         end else begin
            mcand_r  <= mag(data_operandB);
            mplier_r <= mag(data_operandA);
         end
      end else if (busy) begin
         acc_r    <= acc_nxt;
         mplier_r <= mplier_nxt;
      end
   end

   // Result stage: sign/exception fix-up folded into the last iteration edge
   assign mult_fin = finish_mult({acc_nxt, mplier_nxt}, neg_r);
   assign div_fin  = finish_div(mplier_nxt, neg_r, dz_r, ovf_r);

   always_ff @(posedge clock) begin
      if (!reset) begin
         data_result    <= '0;
         data_exception <= 1'b0;
      end else if (busy && tc && !start) begin
         {data_exception, data_result} <= (state == MULT) ? mult_fin : div_fin;
      end
   end

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: expected results queued at start, checked on data_resultRDY.
module tb_multdiv_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] data_operandA = '0;
   logic [31:0] data_operandB = '0;
   logic        ctrl_MULT = 1'b0;
   logic        ctrl_DIV = 1'b0;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;

   typedef struct {
      logic [31:0] res;
      logic        exc;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   prev_rdy = 1'b0;

   multdiv_unit dut (
      .clock          (clock),
      .reset          (reset),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, cycle=%0d", cyc);
      $fatal(1, "watchdog");
   end

   // Scoreboard monitor
   always @(negedge clock) begin
      exp_t e;
      if (data_resultRDY === 1'b1) begin
         n_cmp++;
         if (prev_rdy) begin
            n_bad++;
            $display("FAIL rdy_width: RDY high two cycles in a row at cycle %0d", cyc);
         end else if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_rdy: got result=%h exc=%b at cycle %0d, none expected",
                     data_result, data_exception, cyc);
         end else begin
            e = sb.pop_front();
            if (data_result !== e.res || data_exception !== e.exc || cyc != e.cyc) begin
               n_bad++;
               $display("FAIL result: got %h/%b at cycle %0d, expected %h/%b at cycle %0d",
                        data_result, data_exception, cyc, e.res, e.exc, e.cyc);
            end
         end
      end
      prev_rdy = (data_resultRDY === 1'b1);
   end

   function automatic exp_t model(input bit m, input logic [31:0] a, input logic [31:0] b,
                                  input int c);
      exp_t        e;
      logic [63:0] p;
      int          ai;
      int          bi;
      e.cyc = c;
      if (m) begin
         p     = longint'($signed(a)) * longint'($signed(b));
         e.res = p[31:0];
         e.exc = !((p[63:31] == '0) || (p[63:31] == '1));
      end else if (b == 32'd0) begin
         e.res = 32'd0;
         e.exc = 1'b1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         e.res = 32'h8000_0000;
         e.exc = 1'b1;
      end else begin
         ai    = a;
         bi    = b;
         e.res = ai / bi;
         e.exc = 1'b0;
      end
      return e;
   endfunction

   // Drives a one-cycle start strobe; returns at the negedge following the start edge.
   task automatic start_op(input bit m, input bit d, input logic [31:0] a,
                           input logic [31:0] b, input bit push);
      @(negedge clock);
      ctrl_MULT     = m;
      ctrl_DIV      = d;
      data_operandA = a;
      data_operandB = b;
      @(negedge clock);
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
      if (push) sb.push_back(model(m, a, b, cyc + 32));
   endtask

   task automatic wait_done(output int busy_cnt, output bit seen);
      busy_cnt = 0;
      seen     = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (data_resultRDY === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (busy === 1'b1) busy_cnt++;
         @(negedge clock);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clock);
      n_cmp += 4;
      if (data_result !== 32'd0) begin n_bad++; $display("FAIL reset_result: got %h want 0", data_result); end
      if (data_exception !== 1'b0) begin n_bad++; $display("FAIL reset_exc: got %b want 0", data_exception); end
      if (data_resultRDY !== 1'b0) begin n_bad++; $display("FAIL reset_rdy: got %b want 0", data_resultRDY); end
      if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      ctrl_MULT     = 1'b1;
      data_operandA = 32'd5;
      data_operandB = 32'd5;
      @(negedge clock);
      ctrl_MULT = 1'b0;
      reset     = 1'b1;
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_priority: busy got %b want 0", busy); end
      repeat (2) @(negedge clock);
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_start_discarded: busy got %b want 0", busy); end
   endtask

   task automatic run_one(input bit m, input bit d, input logic [31:0] a,
                          input logic [31:0] b, input string name);
      int bc;
      bit seen;
      start_op(m, d, a, b, 1'b1);
      wait_done(bc, seen);
      n_cmp += 2;
      if (!seen) begin n_bad++; $display("FAIL %s_timeout: no RDY within 40 cycles", name); end
      if (bc != 32) begin n_bad++; $display("FAIL %s_busy_cycles: got %0d want 32", name, bc); end
   endtask

   task automatic test_mult();
      run_one(1, 0, 32'd7, -32'sd6, "mult_7x-6");
      run_one(1, 0, 32'h0001_0000, 32'h0001_0000, "mult_ovf");
      run_one(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, "mult_intmin_neg1");
      run_one(1, 0, 32'h8000_0000, 32'd1, "mult_intmin_1");
      run_one(1, 0, -32'sd3, -32'sd5, "mult_neg_neg");
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_in_done: got %b want 0", busy); end
   endtask

   task automatic test_div();
      run_one(0, 1, -32'sd7, 32'd2, "div_-7/2");
      run_one(0, 1, 32'd5, 32'd0, "div_by_zero");
      run_one(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, "div_intmin_neg1");
      run_one(0, 1, -32'sd100, 32'd7, "div_-100/7");
      run_one(0, 1, 32'd7, -32'sd100, "div_small");
      run_one(0, 1, 32'hFFFF_FFFF, 32'h8000_0000, "div_neg1_intmin");
   endtask

   task automatic test_abort();
      int bc;
      bit seen;
      start_op(0, 1, 32'd100, 32'd7, 1'b0);
      repeat (8) @(negedge clock);
      start_op(1, 0, 32'd3, 32'd4, 1'b1);
      wait_done(bc, seen);
      n_cmp += 2;
      if (!seen) begin n_bad++; $display("FAIL abort_timeout: no RDY for second op"); end
      if (bc != 32) begin n_bad++; $display("FAIL abort_busy_cycles: got %0d want 32", bc); end
   endtask

   task automatic test_reset_abort();
      int rdy_cnt;
      start_op(1, 0, 32'd9, 32'd9, 1'b0);
      repeat (14) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      n_cmp++;
      if (data_result !== 32'd0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_abort_outputs: got result=%h exc=%b rdy=%b busy=%b want all 0",
                  data_result, data_exception, data_resultRDY, busy);
      end
      rdy_cnt = 0;
      repeat (40) begin
         @(negedge clock);
         if (data_resultRDY === 1'b1) rdy_cnt++;
      end
      n_cmp++;
      if (rdy_cnt != 0) begin n_bad++; $display("FAIL reset_abort_rdy: got %0d pulses want 0", rdy_cnt); end
   endtask

   task automatic test_both_strobes();
      run_one(1, 1, 32'd12, 32'd3, "both_strobes");
   endtask

   task automatic test_back_to_back();
      int bc;
      bit seen;
      run_one(1, 0, 32'd11, 32'd13, "b2b_first");
      ctrl_DIV      = 1'b1;
      data_operandA = -32'sd100;
      data_operandB = 32'd9;
      @(negedge clock);
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
      sb.push_back(model(0, -32'sd100, 32'd9, cyc + 32));
      wait_done(bc, seen);
      n_cmp += 2;
      if (!seen) begin n_bad++; $display("FAIL b2b_timeout: no RDY for start in DONE"); end
      if (bc != 32) begin n_bad++; $display("FAIL b2b_busy_cycles: got %0d want 32", bc); end
   endtask

   task automatic test_hold();
      int bc;
      bit seen;
      run_one(1, 0, 32'd1000, -32'sd3, "hold_first");
      repeat (5) @(negedge clock);
      n_cmp++;
      if (data_result !== 32'hFFFF_F448 || data_exception !== 1'b0) begin
         n_bad++;
         $display("FAIL hold_idle: got %h/%b want fffff448/0", data_result, data_exception);
      end
      start_op(0, 1, 32'd50, 32'd0, 1'b1);
      repeat (10) @(negedge clock);
      n_cmp++;
      if (data_result !== 32'hFFFF_F448 || data_exception !== 1'b0) begin
         n_bad++;
         $display("FAIL hold_busy: got %h/%b want fffff448/0", data_result, data_exception);
      end
      wait_done(bc, seen);
      n_cmp++;
      if (!seen) begin n_bad++; $display("FAIL hold_timeout: no RDY"); end
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [31:0] b;
      bit          m;
      for (int i = 0; i < 10; i++) begin
         m = i[0];
         a = m ? 32'($urandom_range(0, 200000) - 100000) : $urandom;
         b = m ? 32'($urandom_range(0, 200000) - 100000) : 32'($urandom_range(0, 2000) - 1000);
         run_one(m, !m, a, b, "random");
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_abort();
      test_reset_abort();
      test_both_strobes();
      test_back_to_back();
      test_hold();
      test_random();
      repeat (5) @(negedge clock);
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: %0d results never arrived, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
